// File: rtl/rf_msg_write_sequencer.sv
// Round-robin burst arbiter for the single write port of the message register file.
// Sequences write addresses for the granted burst, then holds the message until acknowledged.
module rf_msg_write_sequencer #(
  parameter int unsigned DEPTH      = 11,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] len0,
  input  logic                  valid0,
  input  logic [WIDTH-1:0]      data0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] len1,
  input  logic                  valid1,
  input  logic [WIDTH-1:0]      data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  pop0,
  output logic                  pop1,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wa,
  output logic [WIDTH-1:0]      rf_di,
  output logic                  rf_re,
  output logic                  msg_ready,
  output logic                  msg_src,
  output logic [ADDR_WIDTH-1:0] msg_len,
  input  logic                  msg_ack
);

  localparam logic [ADDR_WIDTH-1:0] MaxLen = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic                  src_q;
  logic                  rr_ptr_q;
  logic                  gnt0_q;
  logic                  gnt1_q;

  logic                  winner;
  logic [ADDR_WIDTH-1:0] win_len;
  logic [ADDR_WIDTH-1:0] win_len_clamped;
  logic                  valid_src;
  logic [WIDTH-1:0]      data_src;

  // Contention is resolved by the round-robin pointer; a lone request always wins.
  always_comb begin
    winner          = (req0 && req1) ? rr_ptr_q : req1;
    win_len         = winner ? len1 : len0;
    win_len_clamped = (win_len > MaxLen) ? MaxLen : win_len;
    valid_src       = src_q ? valid1 : valid0;
    data_src        = src_q ? data1 : data0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      src_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            src_q <= winner;
            cnt_q <= '0;
            len_q <= win_len_clamped;
            // A zero-length message has nothing to write, so the port is never granted.
            if (win_len_clamped == '0) begin
              state_q <= StHold;
            end else begin
              state_q <= StWrite;
              gnt0_q  <= ~winner;
              gnt1_q  <= winner;
            end
          end
        end
        StWrite: begin
          if (valid_src) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              state_q <= StHold;
              gnt0_q  <= 1'b0;
              gnt1_q  <= 1'b0;
            end
          end
        end
        StHold: begin
          if (msg_ack) begin
            state_q  <= StIdle;
            rr_ptr_q <= ~src_q;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pop0      = 1'b0;
    pop1      = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_di     = '0;
    rf_re     = 1'b0;
    msg_ready = 1'b0;
    msg_src   = 1'b0;
    msg_len   = '0;
    case (state_q)
      StWrite: begin
        rf_we = valid_src;
        rf_wa = cnt_q;
        rf_di = data_src;
        pop0  = valid_src & ~src_q;
        pop1  = valid_src & src_q;
      end
      StHold: begin
        rf_re     = 1'b1;
        msg_ready = 1'b1;
        msg_src   = src_q;
        msg_len   = len_q;
      end
      default: ;
    endcase
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;

  // Invariants of a single in-flight burst.
  a_wa_in_range: assert property (@(posedge clk) disable iff (!rst)
    rf_we |-> (rf_wa < MaxLen));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst)
    !(gnt0 && gnt1));
  a_pop_granted: assert property (@(posedge clk) disable iff (!rst)
    (!(pop0 && !gnt0)) && (!(pop1 && !gnt1)));
  a_no_write_in_hold: assert property (@(posedge clk) disable iff (!rst)
    msg_ready |-> !rf_we);

endmodule
